// File: rtl/iram_ctrl.sv
// iram_ctrl: instruction-RAM controller. Runs a post-reset BOOT phase in which
// only the loader is served, then arbitrates single-cycle RAM accesses between
// the fetch stage (read only) and the loader/debug port (read or write).
// Fetch is protected from starvation by a saturating denied-cycle counter.
// Read data is returned through registered responses, one cycle after grant.
// Optional: define IRAM_CTRL_PERF_EN to add fetch-grant / fetch-stall counters.
module iram_ctrl #(
    parameter int DW         = 32,
    parameter int AW         = 12,
    parameter int STARVE_MAX = 4,
    parameter int SKIP_BOOT  = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          ld_done,
    output logic          boot_busy,
    output logic          ram_rd_en,
    output logic [AW-1:0] ram_rd_addr,
    input  logic [DW-1:0] ram_rd_data,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_wr_addr,
    output logic [DW-1:0] ram_wr_data
`ifdef IRAM_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_stall_cnt
`endif
);

    typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

    localparam state_t     RST_STATE  = (SKIP_BOOT != 0) ? S_RUN : S_BOOT;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t        state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          fetch_win;
    logic          if_rvalid_q, ld_rvalid_q;
    logic [DW-1:0] if_rdata_q, ld_rdata_q;

    // State register: BOOT until the loader signals completion, then RUN forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RST_STATE;
        else        state_q <= state_d;
    end

    // Next state: ld_done only matters in BOOT; RUN has no way back except reset.
    always_comb begin
        state_d = state_q;
        if (state_q == S_BOOT && ld_done) state_d = S_RUN;
    end

    // Grant and RAM-port outputs: loader wins unless fetch has starved long enough.
    always_comb begin
        boot_busy   = (state_q == S_BOOT);
        fetch_win   = (state_q == S_RUN) && if_req &&
                      (!ld_req || (starve_q >= STARVE_LIM));
        if_gnt      = fetch_win;
        ld_gnt      = ld_req && !fetch_win;
        ram_rd_en   = fetch_win || (ld_gnt && !ld_we);
        ram_rd_addr = fetch_win ? if_addr : ld_addr;
        ram_wr_en   = ld_gnt && ld_we;
        ram_wr_addr = ld_addr;
        ram_wr_data = ld_wdata;
    end

    // Starvation counter: counts consecutive denied fetch requests, saturating at 15.
    always_comb begin
        starve_d = 4'd0;
        if (if_req && !if_gnt) starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= 4'd0;
        else        starve_q <= starve_d;
    end

    // Read responses: capture RAM data for the granted reader, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ld_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= fetch_win;
            ld_rvalid_q <= ld_gnt && !ld_we;
            if (fetch_win)         if_rdata_q <= ram_rd_data;
            if (ld_gnt && !ld_we)  ld_rdata_q <= ram_rd_data;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ld_rvalid = ld_rvalid_q;
    assign ld_rdata  = ld_rdata_q;

`ifdef IRAM_CTRL_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Performance counters: fetch grants and denied fetch cycles, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (if_gnt)            perf_fetch_q <= perf_fetch_q + 32'd1;
            if (if_req && !if_gnt) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_iram_ctrl.sv
// Self-checking bench for iram_ctrl: directed scenarios plus randomized traffic,
// all compared against a cycle-level reference model of the arbitration rules
// and an independent copy of the RAM contents.
module tb_iram_ctrl;

    localparam int DW         = 32;
    localparam int AW         = 12;
    localparam int STARVE_MAX = 4;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ld_req, ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          ld_done, boot_busy;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_rd_data, ram_wr_data;
`ifdef IRAM_CTRL_PERF_EN
    logic [31:0]   perf_fetch_cnt, perf_stall_cnt;
`endif

    iram_ctrl #(.DW(DW), .AW(AW), .STARVE_MAX(STARVE_MAX), .SKIP_BOOT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .ld_done(ld_done), .boot_busy(boot_busy),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data)
`ifdef IRAM_CTRL_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // RAM: combinational read, write on negedge.
    logic [DW-1:0] mem [1<<AW];
    logic          ram_clear;
    assign ram_rd_data = mem[ram_rd_addr];
    always @(negedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
        end else if (ram_wr_en) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] ref_mem [1<<AW];
    bit            m_boot;
    int            m_starve;
    bit            m_if_rv, m_ld_rv;
    logic [DW-1:0] m_if_rd, m_ld_rd;
    logic [31:0]   m_fetch, m_stall;
    bit            last_if_gnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_boot   = 1'b1;
        m_starve = 0;
        m_if_rv  = 1'b0;
        m_ld_rv  = 1'b0;
        m_if_rd  = '0;
        m_ld_rd  = '0;
        m_fetch  = '0;
        m_stall  = '0;
    endtask

    // One clock cycle: inputs already applied; check at negedge, advance model at posedge.
    task automatic cycle();
        bit e_if, e_ld, e_wr, e_rd;
        @(negedge clk);
        e_if = !m_boot && if_req && (!ld_req || m_starve >= STARVE_MAX);
        e_ld = ld_req && !e_if;
        e_wr = e_ld && ld_we;
        e_rd = e_if || (e_ld && !ld_we);
        last_if_gnt = if_gnt;
        check("if_gnt",    32'(if_gnt),    32'(e_if));
        check("ld_gnt",    32'(ld_gnt),    32'(e_ld));
        check("boot_busy", 32'(boot_busy), 32'(m_boot));
        check("if_rvalid", 32'(if_rvalid), 32'(m_if_rv));
        check("ld_rvalid", 32'(ld_rvalid), 32'(m_ld_rv));
        check("if_rdata",  if_rdata,       m_if_rd);
        check("ld_rdata",  ld_rdata,       m_ld_rd);
        check("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
        check("ram_rd_en", 32'(ram_rd_en), 32'(e_rd));
        if (e_wr) begin
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(ld_addr));
            check("ram_wr_data", ram_wr_data, ld_wdata);
        end
        if (e_rd) check("ram_rd_addr", 32'(ram_rd_addr), 32'(e_if ? if_addr : ld_addr));
`ifdef IRAM_CTRL_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_stall", perf_stall_cnt, m_stall);
`endif
        @(posedge clk);
        m_if_rv = e_if;
        if (e_if) m_if_rd = ref_mem[if_addr];
        m_ld_rv = e_ld && !ld_we;
        if (e_ld && !ld_we) m_ld_rd = ref_mem[ld_addr];
        if (e_wr) ref_mem[ld_addr] = ld_wdata;
        if (e_if) m_fetch = m_fetch + 1;
        if (if_req && !e_if) m_stall = m_stall + 1;
        m_starve = (if_req && !e_if) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
        if (m_boot && ld_done) m_boot = 1'b0;
        #1;
    endtask

    task automatic idle();
        if_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0; ld_done = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        rst_n = 1'b0; ram_clear = 1'b1;
        if_addr = '0; ld_addr = '0; ld_wdata = '0;
        idle();
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_boot_busy", 32'(boot_busy), 32'd1);
        check("rst_if_gnt",    32'(if_gnt),    32'd0);
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_if_rdata",  if_rdata,       32'd0);
        check("rst_ld_rdata",  ld_rdata,       32'd0);
        rst_n = 1'b1; ram_clear = 1'b0;
        @(posedge clk); #1;

        // BOOT: loader write while fetch requests; fetch must be held off.
        if_req = 1'b1; if_addr = 12'd4;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'd4; ld_wdata = 32'h00500293;
        cycle();
        ld_req = 1'b0;
        repeat (3) cycle();
        ld_done = 1'b1;
        cycle();
        ld_done = 1'b0;
        cycle();
        cycle();
        check("boot_fetch_data", if_rdata, 32'h00500293);

        // Read-after-write across consecutive grants.
        idle();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'd7; ld_wdata = 32'hDEADBEEF;
        cycle();
        idle();
        if_req = 1'b1; if_addr = 12'd7;
        cycle();
        idle();
        check("raw_data", if_rdata, 32'hDEADBEEF);
        cycle();

        // Starvation: both requesting continuously, fetch wins every 5th cycle.
        if_req = 1'b1; if_addr = 12'd5;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'd4;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            pat[i] = last_if_gnt;
        end
        check("starve_pattern", 32'(pat), 32'h210);
        idle();
        cycle();

        // Contention between loader read and fetch read.
        if_req = 1'b1; if_addr = 12'd5; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 12'd4;
        cycle();
        ld_req = 1'b0;
        cycle();
        idle();
        repeat (2) cycle();

        // Randomized traffic in RUN.
        for (int i = 0; i < 300; i++) begin
            if_req   = ($urandom_range(0, 3) != 0);
            if_addr  = 12'($urandom_range(0, 15));
            ld_req   = ($urandom_range(0, 2) != 0);
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 12'($urandom_range(0, 15));
            ld_wdata = $urandom;
            ld_done  = ($urandom_range(0, 24) == 0);
            cycle();
        end

        // Reset dropped the cycle after a read grant: response is discarded.
        idle();
        if_req = 1'b1; if_addr = 12'd5;
        cycle();
        rst_n = 1'b0;
        m_reset();
        #1;
        check("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("midrst_if_rdata",  if_rdata,       32'd0);
        check("midrst_boot_busy", 32'(boot_busy), 32'd1);
`ifdef IRAM_CTRL_PERF_EN
        check("midrst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("midrst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic starting again from BOOT.
        for (int i = 0; i < 300; i++) begin
            if_req   = ($urandom_range(0, 3) != 0);
            if_addr  = 12'($urandom_range(0, 15));
            ld_req   = ($urandom_range(0, 2) != 0);
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 12'($urandom_range(0, 15));
            ld_wdata = $urandom;
            ld_done  = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
